// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - round-robin sharing of one iterative divider among N requesters
module div_share_arbiter #(
    parameter int W   = 8,
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] dvsr_bus,
    input  logic [N*W-1:0] dvdn_bus,
    output logic [N-1:0]   gnt,
    output logic           busy,
    output logic           rsp_valid,
    output logic [IDW-1:0] rsp_id,
    output logic [W-1:0]   rsp_quo,
    output logic [W-1:0]   rsp_rem,
    output logic           rsp_dz,
    output logic           div_start,
    output logic [W-1:0]   div_dvsr,
    output logic [W-1:0]   div_dvdn,
    input  logic           div_ready,
    input  logic           div_done_tick,
    input  logic [W-1:0]   div_quo,
    input  logic [W-1:0]   div_rem
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id_r;
    logic [IDW-1:0] rsp_id_r;
    logic [W-1:0]   dvsr_r;
    logic [W-1:0]   dvdn_r;
    logic [W-1:0]   quo_r;
    logic [W-1:0]   rem_r;
    logic           dz_r;

    logic           found;
    logic [IDW-1:0] win;
    logic [IDW:0]   idx;
    logic [W-1:0]   sel_dvsr;
    logic [W-1:0]   sel_dvdn;

    // Scan from ptr upward, wrapping at N, and take the first active request.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(N)) begin
                idx = idx - (IDW+1)'(N);
            end
            if (!found && req[idx[IDW-1:0]]) begin
                found = 1'b1;
                win   = idx[IDW-1:0];
            end
        end
    end

    assign sel_dvsr = dvsr_bus[int'(win)*W +: W];
    assign sel_dvdn = dvdn_bus[int'(win)*W +: W];

    always_comb begin
        gnt = '0;
        if (state == IDLE && found && !rst) begin
            gnt[win] = 1'b1;
        end
    end

    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign div_start = (state == ISSUE) && div_ready;
    assign div_dvsr  = dvsr_r;
    assign div_dvdn  = dvdn_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_quo   = quo_r;
    assign rsp_rem   = rem_r;
    assign rsp_dz    = dz_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            id_r     <= '0;
            rsp_id_r <= '0;
            dvsr_r   <= '0;
            dvdn_r   <= '0;
            quo_r    <= '0;
            rem_r    <= '0;
            dz_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        id_r   <= win;
                        dvsr_r <= sel_dvsr;
                        dvdn_r <= sel_dvdn;
                        ptr    <= (win == IDW'(N-1)) ? '0 : win + 1'b1;
                        // Zero divisor is answered here; the divider never sees it.
                        if (sel_dvsr == '0) begin
                            quo_r    <= '1;
                            rem_r    <= sel_dvdn;
                            dz_r     <= 1'b1;
                            rsp_id_r <= win;
                            state    <= RESP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (div_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (div_done_tick) begin
                        quo_r    <= div_quo;
                        rem_r    <= div_rem;
                        dz_r     <= 1'b0;
                        rsp_id_r <= id_r;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb/tb_div_share_arbiter.sv - randomized bench for div_share_arbiter against a transaction-level model
module tb_div_share_arbiter;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] dvsr_bus;
    logic [N*W-1:0] dvdn_bus;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_quo;
    logic [W-1:0]   rsp_rem;
    logic           rsp_dz;
    logic           div_start;
    logic [W-1:0]   div_dvsr;
    logic [W-1:0]   div_dvdn;
    logic           div_ready;
    logic           div_done_tick;
    logic [W-1:0]   div_quo;
    logic [W-1:0]   div_rem;

    div_share_arbiter #(.W(W), .N(N), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req(req), .dvsr_bus(dvsr_bus), .dvdn_bus(dvdn_bus),
        .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_quo(rsp_quo), .rsp_rem(rsp_rem), .rsp_dz(rsp_dz),
        .div_start(div_start), .div_dvsr(div_dvsr), .div_dvdn(div_dvdn),
        .div_ready(div_ready), .div_done_tick(div_done_tick),
        .div_quo(div_quo), .div_rem(div_rem)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int         ptr_m;
    logic [W-1:0] a_dvdn [N];
    logic [W-1:0] a_dvsr [N];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr_m + k) % N]) return (ptr_m + k) % N;
        end
        return -1;
    endfunction

    task automatic pack_buses();
        for (int i = 0; i < N; i++) begin
            dvdn_bus[i*W +: W] = a_dvdn[i];
            dvsr_bus[i*W +: W] = a_dvsr[i];
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rsp"}, {rsp_valid, rsp_id, rsp_quo, rsp_rem, rsp_dz}, 0);
        check({tag, "_div"}, {div_start, div_dvsr, div_dvdn}, 0);
    endtask

    task automatic run_op(input logic [N-1:0] mask, input bit rnd, input int rdly,
                          input int lat, input bit stray, input bit hold, output int w);
        logic [W-1:0] dd, ds;
        if (rnd) begin
            for (int i = 0; i < N; i++) begin
                a_dvdn[i] = W'($urandom);
                a_dvsr[i] = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 255));
            end
        end
        pack_buses();
        w   = pick(mask);
        req = mask;
        @(negedge clk);
        check("grant", gnt, 32'(1) << w);
        check("idle_busy", busy, 0);
        dd    = a_dvdn[w];
        ds    = a_dvsr[w];
        ptr_m = (w + 1) % N;
        nxt();
        if (!hold) req = '0;
        if (ds == 0) begin
            @(negedge clk);
            check("dz_valid", rsp_valid, 1);
            check("dz_id", rsp_id, w);
            check("dz_quo", rsp_quo, 8'hFF);
            check("dz_rem", rsp_rem, dd);
            check("dz_flag", rsp_dz, 1);
            check("dz_nostart", div_start, 0);
            check("dz_gnt", gnt, 0);
            nxt();
        end else begin
            div_ready = 1'b0;
            for (int i = 0; i < rdly; i++) begin
                div_done_tick = stray && (i == 0);
                div_quo = W'($urandom);
                div_rem = W'($urandom);
                @(negedge clk);
                check("issue_nostart", div_start, 0);
                check("issue_busy", busy, 1);
                check("issue_gnt", gnt, 0);
                check("issue_norsp", rsp_valid, 0);
                nxt();
                div_done_tick = 1'b0;
            end
            div_ready = 1'b1;
            @(negedge clk);
            check("start", div_start, 1);
            check("start_dvsr", div_dvsr, ds);
            check("start_dvdn", div_dvdn, dd);
            check("start_gnt", gnt, 0);
            nxt();
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                check("wait_nostart", div_start, 0);
                check("wait_norsp", rsp_valid, 0);
                check("wait_gnt", gnt, 0);
                check("wait_dvsr", div_dvsr, ds);
                nxt();
            end
            div_done_tick = 1'b1;
            div_quo = dd / ds;
            div_rem = dd % ds;
            @(negedge clk);
            check("done_norsp", rsp_valid, 0);
            nxt();
            div_done_tick = 1'b0;
            div_quo = W'($urandom);
            div_rem = W'($urandom);
            @(negedge clk);
            check("rsp_valid", rsp_valid, 1);
            check("rsp_id", rsp_id, w);
            check("rsp_quo", rsp_quo, dd / ds);
            check("rsp_rem", rsp_rem, dd % ds);
            check("rsp_dz", rsp_dz, 0);
            check("rsp_gnt", gnt, 0);
            nxt();
        end
        if (!hold) begin
            @(negedge clk);
            check("post_idle", {busy, rsp_valid, gnt}, 0);
            check("post_hold_quo", rsp_quo, (ds == 0) ? 8'hFF : dd / ds);
            check("post_hold_id", rsp_id, w);
            nxt();
        end
    endtask

    initial begin
        int w;
        logic [N-1:0] m;
        rst = 1'b1; req = '0; div_ready = 1'b1; div_done_tick = 1'b0;
        div_quo = '0; div_rem = '0; dvsr_bus = '0; dvdn_bus = '0;
        ptr_m = 0;
        nxt(); nxt();
        @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        nxt();

        for (int i = 0; i < N; i++) begin a_dvdn[i] = 8'd9; a_dvsr[i] = 8'd3; end
        a_dvdn[2] = 8'd100; a_dvsr[2] = 8'd7;
        run_op(4'b0100, 0, 0, 3, 0, 0, w);
        check("single_id", w, 2);

        a_dvdn[0] = 8'd55; a_dvsr[0] = 8'd0;
        run_op(4'b0001, 0, 0, 0, 0, 0, w);

        // Reset together with a request: no grant.
        rst = 1'b1; req = 4'hF;
        @(negedge clk);
        check("rst_req_gnt", gnt, 0);
        nxt();
        rst = 1'b0; req = '0; ptr_m = 0;
        nxt();

        for (int i = 0; i < 8; i++) begin
            run_op(4'hF, 1, 0, $urandom_range(0, 3), 0, 1, w);
            check("rr_order", w, i % 4);
        end
        req = '0;
        nxt();

        for (int i = 0; i < N; i++) begin a_dvdn[i] = 8'd200; a_dvsr[i] = 8'd9; end
        run_op(4'b0010, 0, 5, 2, 1, 0, w);

        div_done_tick = 1'b1;
        @(negedge clk);
        check("stray_idle", {busy, rsp_valid}, 0);
        nxt();
        div_done_tick = 1'b0;
        @(negedge clk);
        check("stray_idle2", {busy, rsp_valid}, 0);
        nxt();

        // Reset while WAIT, then a late done_tick must be ignored.
        a_dvdn[0] = 8'd77; a_dvsr[0] = 8'd5;
        pack_buses();
        req = 4'b0001;
        @(negedge clk);
        check("rw_gnt", gnt, 4'b0001);
        nxt();
        req = '0; div_ready = 1'b1;
        @(negedge clk);
        check("rw_start", div_start, 1);
        nxt();
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0; div_done_tick = 1'b1; div_quo = 8'd15; div_rem = 8'd2;
        ptr_m = 0;
        @(negedge clk);
        check_zero_outputs("rw_after");
        nxt();
        div_done_tick = 1'b0;
        @(negedge clk);
        check("rw_nodone", {busy, rsp_valid}, 0);
        nxt();
        run_op(4'b1001, 1, 0, 1, 0, 0, w);
        check("rw_ptr", w, 0);

        for (int i = 0; i < 40; i++) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            run_op(m, 1, $urandom_range(0, 3), $urandom_range(0, 6),
                   $urandom_range(0, 1), $urandom_range(0, 1), w);
        end
        req = '0;
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
